// File: rtl/fp8_pkg.sv
// Shared FP8 (1 sign, 3 exponent, 4 fraction, bias 3) types and constants
// used by the multiplier arbiter slice.
package fp8_pkg;

    typedef struct packed {
        logic       sign;
        logic [2:0] exp;
        logic [3:0] frac;
    } fp8_t;

    localparam logic [3:0] FP8_BIAS        = 4'd3;
    localparam logic [2:0] FP8_EXP_SPECIAL = 3'd7;

endpackage

// File: rtl/fp8_mul.sv
// Combinational FP8 multiplier with truncated fraction; the over/underflow
// flag is always the top bit of the 4-bit exponent sum, even for special cases.
module fp8_mul
    import fp8_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o,
    output logic       ovf_o
);

    fp8_t       a;
    fp8_t       b;
    fp8_t       res;
    logic [9:0] prod;
    logic [3:0] e;

    always_comb begin
        a    = a_i;
        b    = b_i;
        prod = 10'({1'b1, a.frac}) * 10'({1'b1, b.frac});
        e    = {1'b0, a.exp} + {1'b0, b.exp} + {3'b000, prod[9]} - FP8_BIAS;

        res.sign = a.sign ^ b.sign;
        res.exp  = e[2:0];
        res.frac = prod[9] ? prod[8:5] : prod[7:4];

        if (a_i[6:0] == 7'd0 || b_i[6:0] == 7'd0) begin
            res = '0;
        end else if (a.exp == FP8_EXP_SPECIAL) begin
            res = a;
        end else if (b.exp == FP8_EXP_SPECIAL) begin
            res = b;
        end

        p_o   = res;
        ovf_o = e[3];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr
// wins, wrapping around, reported both one-hot and encoded.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    always_comb begin
        int   idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fp8_mul_arbiter.sv
// Shares one FP8 multiplier among N_REQ requesters through a round-robin
// grant and a two-stage (operand / result) pipeline with response backpressure.
module fp8_mul_arbiter
    import fp8_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [7:0]         rsp_data,
    output logic               rsp_ovf,
    output logic [ID_W-1:0]    rsp_id,
    output logic [15:0]        op_count
);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             s1_v_q, s1_v_d;
    fp8_t             s1_a_q, s1_a_d;
    fp8_t             s1_b_q, s1_b_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic             s2_v_q, s2_v_d;
    logic [7:0]       s2_data_q, s2_data_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic [ID_W-1:0]  s2_id_q, s2_id_d;
    logic [15:0]      op_count_q, op_count_d;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic [7:0]       mul_p;
    logic             mul_ovf;
    logic             s2_free;
    logic             s1_free;
    logic             accept;
    logic             s1_move;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    fp8_mul u_mul (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .p_o   (mul_p),
        .ovf_o (mul_ovf)
    );

    // Ready is gated by rst_n so no requester sees a handshake while in reset.
    always_comb begin
        s2_free   = !s2_v_q || rsp_ready;
        s1_free   = !s1_v_q || s2_free;
        accept    = s1_free && (|req_valid);
        s1_move   = s1_v_q && s2_free;
        req_ready = grant & {N_REQ{s1_free & rst_n}};
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_v_d     = s1_v_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_v_d     = s2_v_q;
        s2_data_d  = s2_data_q;
        s2_ovf_d   = s2_ovf_q;
        s2_id_d    = s2_id_q;
        op_count_d = op_count_q;

        if (accept) begin
            s1_v_d   = 1'b1;
            s1_a_d   = req_a[8*grant_id +: 8];
            s1_b_d   = req_b[8*grant_id +: 8];
            s1_id_d  = grant_id;
            rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end else if (s1_move) begin
            s1_v_d = 1'b0;
        end

        if (s1_move) begin
            s2_v_d    = 1'b1;
            s2_data_d = mul_p;
            s2_ovf_d  = mul_ovf;
            s2_id_d   = s1_id_q;
        end else if (rsp_ready) begin
            s2_v_d = 1'b0;
        end

        if (s2_v_q && rsp_ready && op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            s1_v_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_v_q     <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
            s2_id_q    <= '0;
            op_count_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_v_q     <= s1_v_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_v_q     <= s2_v_d;
            s2_data_q  <= s2_data_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_id_q    <= s2_id_d;
            op_count_q <= op_count_d;
        end
    end

    assign rsp_valid = s2_v_q;
    assign rsp_data  = s2_data_q;
    assign rsp_ovf   = s2_ovf_q;
    assign rsp_id    = s2_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Directed-vector bench for fp8_mul_arbiter: arithmetic, round-robin order,
// backpressure, mid-stream reset and op_count saturation.
module tb_fp8_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_ovf;
    logic [1:0]  rsp_id;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;

    fp8_mul_arbiter #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issues one pair from a single requester and samples the response one
    // cycle after the accepting edge.
    task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b,
                             output logic v, output logic [7:0] d,
                             output logic o, output logic [1:0] rid);
        bit got;
        got = 1'b0;
        @(negedge clk);
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        req_valid        = 4'b0001 << id;
        rsp_ready        = 1'b1;
        for (int t = 0; t < 8; t++) begin
            #1;
            if (req_ready[id]) begin
                got = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL accept_timeout req=%0d: req_ready never rose, required within 8 cycles", id);
        end
        @(posedge clk);
        @(negedge clk);
        v   = rsp_valid;
        d   = rsp_data;
        o   = rsp_ovf;
        rid = rsp_id;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = {4{8'h30}};
        req_b     = {4{8'h30}};
        rsp_ready = 1'b1;
        #3;
        checks++;
        if ({rsp_valid, rsp_data, rsp_ovf, rsp_id} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got valid=%b data=%h ovf=%b id=%0d, required all zero",
                     rsp_valid, rsp_data, rsp_ovf, rsp_id);
        end
        checks++;
        if (op_count !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_count: got %h, required 0000", op_count);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, required 0000", req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL post_reset_ready: got %b, required 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_arith();
        logic [7:0] ta [5] = '{8'h38, 8'h30, 8'h60, 8'h00, 8'h75};
        logic [7:0] tb [5] = '{8'h38, 8'h30, 8'h60, 8'h30, 8'h30};
        logic [7:0] td [5] = '{8'h42, 8'h30, 8'h10, 8'h00, 8'h75};
        logic       to [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int         tid[5] = '{0, 0, 1, 2, 3};
        logic       v, o;
        logic [7:0] d;
        logic [1:0] rid;
        for (int i = 0; i < 5; i++) begin
            single_op(tid[i], ta[i], tb[i], v, d, o, rid);
            checks++;
            if ({v, o, rid, d} !== {1'b1, to[i], 2'(tid[i]), td[i]}) begin
                errors++;
                $display("[TB] FAIL arith_%0d %h*%h: got valid=%b ovf=%b id=%0d data=%h, required valid=1 ovf=%b id=%0d data=%h",
                         i, ta[i], tb[i], v, o, rid, d, to[i], tid[i], td[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] bv [4] = '{8'h30, 8'h38, 8'h40, 8'h48};
        logic [1:0] eid;
        apply_reset();
        req_a     = {4{8'h30}};
        req_b     = {bv[3], bv[2], bv[1], bv[0]};
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            checks++;
            if (req_ready !== (4'b0001 << (j % 4))) begin
                errors++;
                $display("[TB] FAIL rr_grant_%0d: got %b, required %b", j, req_ready, 4'b0001 << (j % 4));
            end
            if (j >= 2) begin
                eid = 2'((j - 2) % 4);
                checks++;
                if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, eid, bv[eid]}) begin
                    errors++;
                    $display("[TB] FAIL rr_rsp_%0d: got valid=%b id=%0d data=%h, required valid=1 id=%0d data=%h",
                             j, rsp_valid, rsp_id, rsp_data, eid, bv[eid]);
                end
            end
        end
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (op_count !== 16'd10) begin
            errors++;
            $display("[TB] FAIL rr_count: got %0d, required 10", op_count);
        end
    endtask

    task automatic test_backpressure();
        int          accepts;
        logic [11:0] snap;
        apply_reset();
        accepts   = 0;
        snap      = '0;
        req_a     = {8'h30, 8'h30, 8'h60, 8'h38};
        req_b     = {8'h30, 8'h30, 8'h60, 8'h38};
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            accepts += $countones(req_ready & req_valid);
            if (j == 2) begin
                snap = {rsp_valid, rsp_ovf, rsp_id, rsp_data};
                checks++;
                if (snap !== {1'b1, 1'b0, 2'd0, 8'h42}) begin
                    errors++;
                    $display("[TB] FAIL bp_head: got %h, required %h", snap, {1'b1, 1'b0, 2'd0, 8'h42});
                end
            end
            if (j >= 2) begin
                checks++;
                if (req_ready !== 4'b0000) begin
                    errors++;
                    $display("[TB] FAIL bp_ready_%0d: got %b, required 0000", j, req_ready);
                end
            end
            if (j >= 3) begin
                checks++;
                if ({rsp_valid, rsp_ovf, rsp_id, rsp_data} !== {1'b1, 1'b0, 2'd0, 8'h42}) begin
                    errors++;
                    $display("[TB] FAIL bp_stable_%0d: got %h, required %h", j,
                             {rsp_valid, rsp_ovf, rsp_id, rsp_data}, {1'b1, 1'b0, 2'd0, 8'h42});
                end
            end
        end
        checks++;
        if (accepts !== 2) begin
            errors++;
            $display("[TB] FAIL bp_accepts: got %0d, required 2", accepts);
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_ovf, rsp_id, rsp_data} !== {1'b1, 1'b0, 2'd0, 8'h42}) begin
            errors++;
            $display("[TB] FAIL bp_drain0: got %h, required %h",
                     {rsp_valid, rsp_ovf, rsp_id, rsp_data}, {1'b1, 1'b0, 2'd0, 8'h42});
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_ovf, rsp_id, rsp_data} !== {1'b1, 1'b1, 2'd1, 8'h10}) begin
            errors++;
            $display("[TB] FAIL bp_drain1: got %h, required %h",
                     {rsp_valid, rsp_ovf, rsp_id, rsp_data}, {1'b1, 1'b1, 2'd1, 8'h10});
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, op_count} !== {1'b0, 16'd2}) begin
            errors++;
            $display("[TB] FAIL bp_empty: got valid=%b count=%0d, required valid=0 count=2", rsp_valid, op_count);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        req_a     = {4{8'h30}};
        req_b     = {4{8'h30}};
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_inflight: got valid=%b, required 1", rsp_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, req_ready, op_count} !== {1'b0, 4'b0000, 16'd0}) begin
            errors++;
            $display("[TB] FAIL mid_async: got valid=%b ready=%b count=%0d, required 0 0000 0",
                     rsp_valid, req_ready, op_count);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL mid_first_grant: got %b, required 0001", req_ready);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mid_no_rsp_%0d: got valid=1, required 0", j);
            end
        end
    endtask

    task automatic test_saturation();
        logic       v, o;
        logic [7:0] d;
        logic [1:0] rid;
        @(negedge clk);
        force dut.op_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.op_count_q;
        for (int i = 0; i < 2; i++) begin
            single_op(0, 8'h30, 8'h30, v, d, o, rid);
            checks++;
            if ({v, d} !== {1'b1, 8'h30}) begin
                errors++;
                $display("[TB] FAIL sat_op_%0d: got valid=%b data=%h, required valid=1 data=30", i, v, d);
            end
            @(negedge clk);
            checks++;
            if (op_count !== 16'hFFFF) begin
                errors++;
                $display("[TB] FAIL sat_count_%0d: got %h, required FFFF", i, op_count);
            end
        end
    endtask

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_arith();
        test_round_robin();
        test_backpressure();
        test_reset_midstream();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp8_mul_arbiter.md
# fp8_mul_arbiter

Shares one FP8 multiplier (1 sign, 3 exponent, 4 fraction bits, bias 3) among `N_REQ` requesters in the systolic matrix multiplier. Each requester presents operand pairs on a valid/ready handshake. A round-robin arbiter grants one pair per cycle into a two-stage pipeline. Results return on a single shared response channel tagged with the requester ID, with backpressure.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID.
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, `N_REQ`: one bit per requester; the operand pair is valid.
- `req_ready`, out, `N_REQ`: one-hot or zero; the pair is accepted when `req_valid[i] & req_ready[i]`.
- `req_a`, in, `8*N_REQ`: operand A, requester i on bits `[8i+7:8i]`.
- `req_b`, in, `8*N_REQ`: operand B, same packing.
- `rsp_valid`, out, 1: a result is present.
- `rsp_ready`, in, 1: the consumer accepts the result.
- `rsp_data`, out, 8: product.
- `rsp_ovf`, out, 1: exponent over/underflow flag from the multiplier.
- `rsp_id`, out, `ID_W`: index of the originating requester.
- `op_count`, out, 16: number of completed responses, saturating.

## Operation
- Arbitration:
  - Pointer `rr_ptr` (`ID_W` bits) marks the highest-priority requester.
  - Grant goes to the first i with `req_valid[i]`, searching from `rr_ptr` upward with wrap.
  - When a pair is accepted from requester g, `rr_ptr <= (g+1) mod N_REQ`. Otherwise the pointer holds.
- `req_ready[i] = grant[i] & s1_free`. `req_ready` may depend combinationally on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- Stage S1 holds the registered A, B and ID, plus `s1_v`.
- Stage S2 holds the registered result, overflow flag and ID, plus `s2_v`, and drives the `rsp_*` outputs directly.
- Pipeline control:
  - `s2_free = !s2_v | rsp_ready`.
  - `s1_free = !s1_v | s2_free`.
  - S1 moves to S2 when `s1_v & s2_free`.
  - A new accept loads S1 when `s1_free` and some request is valid. Otherwise, if S1 moved on, `s1_v` clears.
- Multiply, combinational between S1 and S2, via the team's `MUL` module:
  - If either operand has `[6:0]==0`, the result is `8'h00`.
  - Else if `A[6:4]==7`, the result is A. Else if `B[6:4]==7`, the result is B.
  - Otherwise the product is `P = {1,A[3:0]}*{1,B[3:0]}`, 10 bits.
  - Fraction: `P[8:5]` if `P[9]` is set, else `P[7:4]` (truncated).
  - Exponent temporary: `E = A[6:4]+B[6:4]+P[9]-3`, computed in 4 bits. The exponent field is `E[2:0]`, `ovf = E[3]`.
  - Sign is `A[7]^B[7]`.
  - `ovf` is forwarded unchanged even in the zero and pass-through cases.
- `op_count` increments on `rsp_valid & rsp_ready` and saturates at `16'hFFFF`.
- Responses leave in acceptance order. No reordering, no drops.

## Timing
- Reset values: `s1_v=0`, `s2_v=0`, `rr_ptr=0`, `op_count=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_ovf=0`, `rsp_id=0`. All `req_ready` are 0 only while `rst_n` is low.
- Latency: a pair accepted at edge k gives `rsp_valid=1` after edge k+1, when `rsp_ready` was held high.
- Throughput: one operation per cycle while `rsp_ready=1`.
- Backpressure: with `rsp_ready=0`, S2 holds and S1 holds. At most two operations are in flight. After that, `req_ready` is all zero until `rsp_ready` rises.
- Same-cycle response drain and S1 advance is allowed. No bubble is inserted.
- A single active requester is granted every cycle, regardless of `rr_ptr`.
- Reset asserted mid-operation discards all in-flight operations immediately. No response is emitted for them.
- `rsp_*` outputs are stable while `rsp_valid & !rsp_ready`.

## Structure
- Package `fp8_pkg` holds:
  - the `fp8_t` struct {sign, exp[2:0], frac[3:0]};
  - `FP8_BIAS=3`;
  - `FP8_EXP_SPECIAL=3'd7`.
- One natural sub-module is `rr_arbiter` (inputs `req`, `ptr`; outputs one-hot `grant` and encoded `grant_id`), which is combinational. The multiplier instance sits between S1 and S2.

## Test plan
- Requester 0 only: A=`0x38`, B=`0x38`, `rsp_ready=1` gives `rsp_data=0x42`, `ovf=0`, `id=0`, 2 edges after accept. With A=`0x30`, B=`0x30`, the result is `0x30`.
- Overflow and zero:
  - `0x60`×`0x60` gives `0x10`, `ovf=1`.
  - `0x00`×`0x30` gives `0x00`, `ovf=0`.
  - `0x75`×`0x30` gives `0x75`.
- All 4 requesters valid continuously, `rsp_ready=1`: grants follow 0,1,2,3,0,… one per cycle, and `rsp_id` follows the same sequence.
- Backpressure: hold `rsp_ready=0` for 5 cycles with requests pending. Exactly 2 accepts happen, then all `req_ready` are 0 and `rsp_*` stay stable. Releasing `rsp_ready` drains in order with no loss and no duplicates.
- Assert `rst_n` low mid-stream with 2 operations in flight. `rsp_valid` drops asynchronously, `op_count=0`, and after release the first grant goes to requester 0.
- `op_count` saturation: force 65 540 responses (or preload the counter in the bench). The counter stops at `0xFFFF`.
